xbar_prio_sched: RTL and testbench

Generates the external arbitration priority pointers for a full-duplex crossbar built with external priority enabled. It drives the request-side pointers (one per target) and the response-side pointers (one per initiator). Pointers are updated round-robin from observed handshakes. A per-initiator starvation monitor forces a request-side pointer onto an initiator that has waited too long. The block sits beside the crossbar, snooping both initiator and target ports; it never touches the datapath.

---
 rtl/xbar_prio_sched_pkg.sv | 29 ++
 rtl/xbar_starve_mon.sv | 112 +++++++++++
 rtl/xbar_prio_sched.sv | 118 +++++++++++
 tb/tb_xbar_prio_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/xbar_prio_sched_pkg.sv
// Shared types and index helpers for the crossbar priority-pointer scheduler.
package xbar_prio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STARVED = 2'd2
  } starve_state_e;

  // Widest initiator set the circular scan supports.
  localparam int MaskW = 32;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

  // Unused upper mask bits must be zero, so wrapping over MaskW equals wrapping over NumIn.
  function automatic int circ_first(input logic [MaskW-1:0] mask, input int start);
    int res;
    int idx;
    res = start;
    for (int k = MaskW - 1; k >= 0; k--) begin
      idx = (start + k) % MaskW;
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/xbar_starve_mon.sv
// Single-initiator starvation monitor: IDLE/WAIT/STARVED FSM with saturating stall counter.
// XBAR_PRIO_SCHED_STATS_EN adds a saturating count of STARVED entries.
module xbar_starve_mon
  import xbar_prio_sched_pkg::*;
#(
  parameter int TgtW         = 2,
  parameter int StarveThresh = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_ready,
  input  logic [TgtW-1:0] tgt_addr,
  output logic            starved,
  output logic [TgtW-1:0] stgt
`ifdef XBAR_PRIO_SCHED_STATS_EN
  ,
  output logic [31:0]     event_cnt
`endif
);

  localparam int CntW = $clog2(StarveThresh + 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = CntW'(StarveThresh - 1);

  starve_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TgtW-1:0] stgt_q, stgt_d;
  logic            stall, same_tgt, enter;

  assign stall    = req_valid & ~req_ready;
  assign same_tgt = (tgt_addr == stgt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stgt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stgt_q  <= stgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stgt_d  = stgt_q;
    enter   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stall) begin
          stgt_d = tgt_addr;
          cnt_d  = CntW'(1);
          if (StarveThresh == 1) begin
            state_d = STARVED;
            enter   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A handshake, valid drop or retarget all leave the stall episode.
        if (stall && same_tgt) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = STARVED;
            enter   = 1'b1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      STARVED: begin
        if (stall && same_tgt) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign starved = (state_q == STARVED);
  assign stgt    = stgt_q;

`ifdef XBAR_PRIO_SCHED_STATS_EN
  logic [31:0] event_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q <= '0;
    end else if (enter && (event_q != 32'hFFFF_FFFF)) begin
      event_q <= event_q + 32'd1;
    end
  end

  assign event_cnt = event_q;
`else
  logic unused_enter;
  assign unused_enter = enter;
`endif

endmodule

// File: rtl/xbar_prio_sched.sv
// Round-robin priority pointers for a full-duplex crossbar, with starvation override on request side.
// XBAR_PRIO_SCHED_STATS_EN adds starve_events_o (32-bit saturating STARVED-entry count per initiator).
module xbar_prio_sched
  import xbar_prio_sched_pkg::*;
#(
  parameter int NumIn        = 4,
  parameter int NumOut       = 4,
  parameter int StarveThresh = 16,
  localparam int TgtIniW     = $clog2(NumIn),
  localparam int IniTgtW     = $clog2(NumOut)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumIn-1:0]           req_valid_i,
  input  logic [NumIn-1:0]           req_ready_i,
  input  logic [NumIn*IniTgtW-1:0]   req_tgt_addr_i,
  input  logic [NumOut-1:0]          tgt_req_valid_i,
  input  logic [NumOut-1:0]          tgt_req_ready_i,
  input  logic [NumOut*TgtIniW-1:0]  tgt_req_ini_addr_i,
  input  logic [NumOut-1:0]          tgt_resp_valid_i,
  input  logic [NumOut-1:0]          tgt_resp_ready_i,
  input  logic [NumOut*TgtIniW-1:0]  tgt_resp_ini_addr_i,
  output logic [NumOut*TgtIniW-1:0]  req_rr_o,
  output logic [NumIn*IniTgtW-1:0]   resp_rr_o,
  output logic [NumIn-1:0]           starved_o
`ifdef XBAR_PRIO_SCHED_STATS_EN
  ,
  output logic [NumIn*32-1:0]        starve_events_o
`endif
);

  if (NumIn < 2 || NumIn > MaskW) begin : g_bad_numin
    $fatal(1, "xbar_prio_sched: NumIn must be in 2..32");
  end
  if (NumOut < 2) begin : g_bad_numout
    $fatal(1, "xbar_prio_sched: NumOut must be >= 2");
  end
  if (StarveThresh < 1) begin : g_bad_thresh
    $fatal(1, "xbar_prio_sched: StarveThresh must be >= 1");
  end

  logic [TgtIniW-1:0] ptr_q  [NumOut];
  logic [IniTgtW-1:0] rptr_q [NumIn];
  logic [NumIn-1:0]   starved;
  logic [IniTgtW-1:0] stgt   [NumIn];
  logic [MaskW-1:0]   smask  [NumOut];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < NumOut; t++) ptr_q[t] <= '0;
      for (int i = 0; i < NumIn; i++) rptr_q[i] <= '0;
    end else begin
      for (int t = 0; t < NumOut; t++) begin
        if (tgt_req_valid_i[t] && tgt_req_ready_i[t]) begin
          ptr_q[t] <= TgtIniW'(wrap_inc(int'(tgt_req_ini_addr_i[t*TgtIniW +: TgtIniW]), NumIn));
        end
      end
      // Ascending t with non-blocking updates: the highest responding target wins.
      for (int t = 0; t < NumOut; t++) begin
        for (int i = 0; i < NumIn; i++) begin
          if (tgt_resp_valid_i[t] && tgt_resp_ready_i[t] &&
              tgt_resp_ini_addr_i[t*TgtIniW +: TgtIniW] == TgtIniW'(i)) begin
            rptr_q[i] <= IniTgtW'(wrap_inc(t, NumOut));
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NumIn; i++) begin : g_mon
    xbar_starve_mon #(
      .TgtW         (IniTgtW),
      .StarveThresh (StarveThresh)
    ) u_mon (
      .clk       (clk_i),
      .rst       (rst_i),
      .req_valid (req_valid_i[i]),
      .req_ready (req_ready_i[i]),
      .tgt_addr  (req_tgt_addr_i[i*IniTgtW +: IniTgtW]),
      .starved   (starved[i]),
      .stgt      (stgt[i])
`ifdef XBAR_PRIO_SCHED_STATS_EN
      ,
      .event_cnt (starve_events_o[i*32 +: 32])
`endif
    );
  end

  always_comb begin
    for (int t = 0; t < NumOut; t++) begin
      smask[t] = '0;
      for (int i = 0; i < NumIn; i++) begin
        smask[t][i] = starved[i] && (stgt[i] == IniTgtW'(t));
      end
    end
  end

  always_comb begin
    req_rr_o = '0;
    for (int t = 0; t < NumOut; t++) begin
      if (|smask[t]) begin
        req_rr_o[t*TgtIniW +: TgtIniW] = TgtIniW'(circ_first(smask[t], int'(ptr_q[t])));
      end else begin
        req_rr_o[t*TgtIniW +: TgtIniW] = ptr_q[t];
      end
    end
  end

  always_comb begin
    resp_rr_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      resp_rr_o[i*IniTgtW +: IniTgtW] = rptr_q[i];
    end
  end

  assign starved_o = starved;

endmodule

// File: tb/tb_xbar_prio_sched.sv
// Directed bench for xbar_prio_sched with NumIn=4, NumOut=4, StarveThresh=4.
module tb_xbar_prio_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [3:0] req_valid_i = '0;
  logic [3:0] req_ready_i = '0;
  logic [7:0] req_tgt_addr_i = '0;
  logic [3:0] tgt_req_valid_i = '0;
  logic [3:0] tgt_req_ready_i = '0;
  logic [7:0] tgt_req_ini_addr_i = '0;
  logic [3:0] tgt_resp_valid_i = '0;
  logic [3:0] tgt_resp_ready_i = '0;
  logic [7:0] tgt_resp_ini_addr_i = '0;
  logic [7:0] req_rr_o;
  logic [7:0] resp_rr_o;
  logic [3:0] starved_o;
`ifdef XBAR_PRIO_SCHED_STATS_EN
  logic [127:0] starve_events_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  xbar_prio_sched #(
    .NumIn        (4),
    .NumOut       (4),
    .StarveThresh (4)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_i         (req_ready_i),
    .req_tgt_addr_i      (req_tgt_addr_i),
    .tgt_req_valid_i     (tgt_req_valid_i),
    .tgt_req_ready_i     (tgt_req_ready_i),
    .tgt_req_ini_addr_i  (tgt_req_ini_addr_i),
    .tgt_resp_valid_i    (tgt_resp_valid_i),
    .tgt_resp_ready_i    (tgt_resp_ready_i),
    .tgt_resp_ini_addr_i (tgt_resp_ini_addr_i),
    .req_rr_o            (req_rr_o),
    .resp_rr_o           (resp_rr_o),
    .starved_o           (starved_o)
`ifdef XBAR_PRIO_SCHED_STATS_EN
    ,
    .starve_events_o     (starve_events_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_tgt();
    tgt_req_valid_i     = '0;
    tgt_req_ready_i     = '0;
    tgt_req_ini_addr_i  = '0;
    tgt_resp_valid_i    = '0;
    tgt_resp_ready_i    = '0;
    tgt_resp_ini_addr_i = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-on reset
    #2 rst_i = 1'b1;
    #1;
    chk("rst_init_req_rr", 32'(req_rr_o), 32'h00);
    chk("rst_init_resp_rr", 32'(resp_rr_o), 32'h00);
    chk("rst_init_starved", 32'(starved_o), 32'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // Request pointer advance, no-ready hold, and wrap
    tgt_req_valid_i = 4'b0100; tgt_req_ready_i = 4'b0100; tgt_req_ini_addr_i = 8'h10;
    tick(); clear_tgt();
    chk("req_adv", 32'(req_rr_o), 32'h20);
    tgt_req_valid_i = 4'b0100; tgt_req_ini_addr_i = 8'h30;
    tick();
    chk("req_noready", 32'(req_rr_o), 32'h20);
    tgt_req_ready_i = 4'b0100;
    tick(); clear_tgt();
    chk("req_wrap", 32'(req_rr_o), 32'h00);

    // Response pointer advance, wrap, and multi-target collision
    tgt_resp_valid_i = 4'b0010; tgt_resp_ready_i = 4'b0010; tgt_resp_ini_addr_i = 8'h00;
    tick(); clear_tgt();
    chk("resp_adv", 32'(resp_rr_o), 32'h02);
    tgt_resp_valid_i = 4'b1000; tgt_resp_ready_i = 4'b1000;
    tick(); clear_tgt();
    chk("resp_wrap", 32'(resp_rr_o), 32'h00);
    tgt_resp_valid_i = 4'b0111; tgt_resp_ready_i = 4'b0111; tgt_resp_ini_addr_i = 8'h02;
    tick(); clear_tgt();
    chk("resp_highest_t", 32'(resp_rr_o), 32'h13);

    // Initiator 2 starves on target 1
    req_valid_i = 4'b0100; req_ready_i = 4'b0000; req_tgt_addr_i = 8'h10;
    ticks(3);
    chk("starve_pre", 32'(starved_o), 32'h0);
    tick();
    chk("starve_entry", 32'(starved_o), 32'h4);
    chk("starve_override", 32'(req_rr_o), 32'h08);
    req_ready_i = 4'b0100;
    tgt_req_valid_i = 4'b0010; tgt_req_ready_i = 4'b0010; tgt_req_ini_addr_i = 8'h08;
    tick(); clear_tgt();
    req_valid_i = '0; req_ready_i = '0;
    chk("starve_exit", 32'(starved_o), 32'h0);
    chk("starve_exit_ptr", 32'(req_rr_o), 32'h0C);
`ifdef XBAR_PRIO_SCHED_STATS_EN
    chk("stats_ini2", starve_events_o[95:64], 32'd1);
`endif

    // Circular selection among starved initiators 0 and 3 with ptr_q[1] = 2
    tgt_req_valid_i = 4'b0010; tgt_req_ready_i = 4'b0010; tgt_req_ini_addr_i = 8'h04;
    tick(); clear_tgt();
    chk("ptr1_setup", 32'(req_rr_o), 32'h08);
    req_valid_i = 4'b1001; req_tgt_addr_i = 8'h41;
    ticks(4);
    chk("two_starved", 32'(starved_o), 32'h9);
    chk("circ_sel", 32'(req_rr_o), 32'h0C);
    req_ready_i = 4'b1000;
    tgt_req_valid_i = 4'b0010; tgt_req_ready_i = 4'b0010; tgt_req_ini_addr_i = 8'h0C;
    tick(); clear_tgt();
    req_ready_i = '0; req_valid_i = 4'b0001;
    chk("serve3_starved", 32'(starved_o), 32'h1);
    chk("serve3_sel", 32'(req_rr_o), 32'h00);
    // Pointer moves to 2 while the override keeps initiator 0 selected
    tgt_req_valid_i = 4'b0010; tgt_req_ready_i = 4'b0010; tgt_req_ini_addr_i = 8'h04;
    tick(); clear_tgt();
    chk("override_wins", 32'(req_rr_o), 32'h00);
    req_valid_i = '0;
    tick();
    chk("ptr_updated_under_override", 32'(req_rr_o), 32'h08);
    chk("all_released", 32'(starved_o), 32'h0);

    // Asynchronous reset mid-traffic
    req_valid_i = 4'b0010; req_tgt_addr_i = 8'h08;
    tgt_req_valid_i = 4'b0001; tgt_req_ready_i = 4'b0001; tgt_req_ini_addr_i = 8'h00;
    ticks(2);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_req_rr", 32'(req_rr_o), 32'h00);
    chk("rst_mid_resp_rr", 32'(resp_rr_o), 32'h00);
    chk("rst_mid_starved", 32'(starved_o), 32'h0);
    tick();
    rst_i = 1'b0; req_valid_i = '0; clear_tgt();
    ticks(2);
    chk("rst_hold_req_rr", 32'(req_rr_o), 32'h00);
    chk("rst_hold_resp_rr", 32'(resp_rr_o), 32'h00);

    // Abort by valid drop on the fourth cycle
    req_valid_i = 4'b0010; req_tgt_addr_i = 8'h00;
    ticks(3);
    req_valid_i = '0;
    tick();
    chk("abort_drop", 32'(starved_o), 32'h0);
    tick();
    chk("abort_drop_hold", 32'(starved_o), 32'h0);
`ifdef XBAR_PRIO_SCHED_STATS_EN
    chk("stats_ini1_abort", starve_events_o[63:32], 32'd0);
`endif
    // Counter restarts from scratch, then abort by retarget on the fourth cycle
    req_valid_i = 4'b0010;
    ticks(3);
    chk("cnt_cleared", 32'(starved_o), 32'h0);
    req_tgt_addr_i = 8'h08;
    tick();
    chk("abort_tgt", 32'(starved_o), 32'h0);
    ticks(3);
    chk("retarget_pre", 32'(starved_o), 32'h0);
    tick();
    chk("retarget_starved", 32'(starved_o), 32'h2);
    chk("retarget_sel", 32'(req_rr_o), 32'h10);
    req_valid_i = '0;
    tick();

    // Handshake on the would-be entry cycle wins
    req_valid_i = 4'b0001; req_tgt_addr_i = 8'h03;
    ticks(3);
    req_ready_i = 4'b0001;
    tick();
    chk("hs_wins", 32'(starved_o), 32'h0);
    req_valid_i = '0; req_ready_i = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
